dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_bytemask.sv | 52 +++++
 rtl/dmem_responder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types for the data-memory responder: access size codes,
//            responder FSM states and a size-normalisation helper.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // funct3 size codes for loads/stores
    typedef enum logic [2:0] {
        SZ_B = 3'b000,
        SZ_H = 3'b001,
        SZ_W = 3'b010,
        SZ_D = 3'b011
    } size_e;

    // Responder FSM states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } state_e;

    // Codes 100..111 have no defined width here and behave as a doubleword
    function automatic size_e normSize(input logic [2:0] code);
        return code[2] ? SZ_D : size_e'(code);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bytemask.sv
`default_nettype none
// ============================================================================
// Module   : dmem_bytemask
// Brief    : Combinational decode of access size and address[2:0] into an
//            8-bit byte-enable mask, the starting byte lane and a flag that
//            reports an access not aligned to its own size. The lane is
//            always size-aligned; callers decide what to do with the flag.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_bytemask
    import dmem_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [2:0] i_addrLow,
    output logic [7:0] o_byteMask,
    output logic [2:0] o_laneShift,
    output logic       o_misaligned
);

    size_e w_size;

    // Decode mask, aligned lane and misalignment from the normalised size
    always_comb begin
        w_size       = normSize(i_size);
        o_byteMask   = 8'hFF;
        o_laneShift  = 3'd0;
        o_misaligned = 1'b0;
        case (w_size)
            SZ_B: begin
                o_laneShift  = i_addrLow;
                o_byteMask   = 8'h01 << o_laneShift;
            end
            SZ_H: begin
                o_laneShift  = {i_addrLow[2:1], 1'b0};
                o_byteMask   = 8'h03 << o_laneShift;
                o_misaligned = i_addrLow[0];
            end
            SZ_W: begin
                o_laneShift  = {i_addrLow[2], 2'b00};
                o_byteMask   = 8'h0F << o_laneShift;
                o_misaligned = |i_addrLow[1:0];
            end
            default: begin
                o_laneShift  = 3'd0;
                o_byteMask   = 8'hFF;
                o_misaligned = |i_addrLow;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Single-outstanding data-memory responder with a fixed response
//            latency. Loads return the full aligned doubleword; stores are
//            byte-masked into the addressed word on the edge entering RESPOND.
//            Optional DMEM_MISALIGN_CHECK_EN: misaligned accesses report
//            rsp_err, stores are dropped and read data is zero. Without it,
//            low address bits are forced to size alignment.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] c_LAST_WAIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    state_e               r_state;
    state_e               w_nextState;
    logic [3:0]           r_waitCnt;

    logic                 r_write;
    logic [c_IDX_W-1:0]   r_idx;
    logic [2:0]           r_addrLow;
    logic [2:0]           r_size;
    logic [63:0]          r_wdata;

    logic                 w_accept;
    logic                 w_selWrite;
    logic [c_IDX_W-1:0]   w_selIdx;
    logic [2:0]           w_selAddrLow;
    logic [2:0]           w_selSize;
    logic [63:0]          w_selWdata;
    logic [7:0]           w_byteMask;
    logic [2:0]           w_laneShift;
    logic                 w_misaligned;
    logic                 w_misErr;
    logic [63:0]          w_laneData;
    logic                 w_commit;

    logic [63:0]          r_mem [DEPTH];

`ifdef DMEM_MISALIGN_CHECK_EN
    logic w_unusedBits;
    assign w_unusedBits = ^req_addr[63:c_IDX_W+3];
    assign w_misErr     = w_misaligned;
`else
    logic w_unusedBits;
    assign w_unusedBits = ^{req_addr[63:c_IDX_W+3], w_misaligned};
    assign w_misErr     = 1'b0;
`endif

    assign w_accept = req_valid && req_ready;

    // In IDLE the live request feeds the decode so a zero-latency store can
    // commit on its own accept edge; otherwise the latched request does.
    always_comb begin
        w_selWrite   = r_write;
        w_selIdx     = r_idx;
        w_selAddrLow = r_addrLow;
        w_selSize    = r_size;
        w_selWdata   = r_wdata;
        if (r_state == IDLE) begin
            w_selWrite   = req_write;
            w_selIdx     = req_addr[c_IDX_W+2:3];
            w_selAddrLow = req_addr[2:0];
            w_selSize    = req_size;
            w_selWdata   = req_wdata;
        end
    end

    dmem_bytemask u_bytemask (
        .i_size       (w_selSize),
        .i_addrLow    (w_selAddrLow),
        .o_byteMask   (w_byteMask),
        .o_laneShift  (w_laneShift),
        .o_misaligned (w_misaligned)
    );

    assign w_laneData = w_selWdata << {w_laneShift, 3'b000};
    // Gating with reset keeps a store from landing while reset is held
    assign w_commit   = reset && (w_nextState == RESPOND) && w_selWrite && !w_misErr;

    // Next-state and output decode
    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = 64'd0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_nextState = (LATENCY == 0) ? RESPOND : WAIT;
                end
            end
            WAIT: begin
                if (r_waitCnt == c_LAST_WAIT) begin
                    w_nextState = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid   = 1'b1;
                rsp_err     = w_misErr;
                if (!r_write && !w_misErr) begin
                    rsp_rdata = r_mem[r_idx];
                end
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register and wait-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_waitCnt <= 4'd0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= (r_state == WAIT && w_nextState == WAIT) ? r_waitCnt + 4'd1 : 4'd0;
        end
    end

    // Capture the request fields on accept only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_addrLow <= 3'd0;
            r_size    <= 3'd0;
            r_wdata   <= 64'd0;
        end else if (w_accept) begin
            r_write   <= req_write;
            r_idx     <= req_addr[c_IDX_W+2:3];
            r_addrLow <= req_addr[2:0];
            r_size    <= req_size;
            r_wdata   <= req_wdata;
        end
    end

    // Byte-masked store into the storage array (contents survive reset)
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 8; b++) begin
                if (w_byteMask[b]) begin
                    r_mem[w_selIdx][8*b +: 8] <= w_laneData[8*b +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
